// File: rtl/uart_defs_pkg.sv
// Shared UART definitions: frame geometry and receiver/transmitter state encodings.
package uart_defs_pkg;

    localparam int DATA_BITS      = 8;
    localparam int OVERSAMPLE_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_sync_edge.sv
// Two-flop synchroniser for an asynchronous input plus a registered copy for falling-edge detect.
module uart_sync_edge #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            sync <= RESET_VAL;
            prev <= RESET_VAL;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign fall  = prev & ~sync;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: oversampled mid-bit sampling, hold-until-read byte handshake,
// frame-error pulse and sticky overrun flag.
module uart_receiver
    import uart_defs_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic       clock_160KHz,
    input  logic       Reset_n,
    input  logic       TXD,
    input  logic       RX_Read,
    output logic [7:0] RX_data,
    output logic       Data_Available,
    output logic       Frame_Error,
    output logic       Overrun
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    uart_state_t          state, state_nxt;
    logic [TW-1:0]        tick, tick_nxt;
    logic [BW-1:0]        bit_idx, bit_nxt;
    logic [DATA_BITS-1:0] shreg;
    logic                 line, line_fall;
    logic                 shift_en, capture, frame_err;

    uart_sync_edge #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clock_160KHz),
        .rst_n (Reset_n),
        .din   (TXD),
        .level (line),
        .fall  (line_fall)
    );

    always_ff @(posedge clock_160KHz or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= ST_IDLE;
            tick    <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_nxt;
            tick    <= tick_nxt;
            bit_idx <= bit_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tick_nxt  = tick + 1'b1;
        bit_nxt   = bit_idx;
        shift_en  = 1'b0;
        capture   = 1'b0;
        frame_err = 1'b0;
        case (state)
            ST_IDLE: begin
                tick_nxt = '0;
                if (line_fall) state_nxt = ST_START;
            end
            ST_START: begin
                if (tick == TICK_MID) begin
                    tick_nxt  = '0;
                    bit_nxt   = '0;
                    // A high line at mid start bit is a glitch, not a frame
                    state_nxt = line ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick == TICK_LAST) begin
                    tick_nxt = '0;
                    shift_en = 1'b1;
                    if (bit_idx == BIT_LAST) state_nxt = ST_STOP;
                    else                     bit_nxt   = bit_idx + 1'b1;
                end
            end
            ST_STOP: begin
                if (tick == TICK_LAST) begin
                    tick_nxt = '0;
                    if (line) begin
                        capture   = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_nxt = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                tick_nxt = '0;
                if (line) state_nxt = ST_IDLE;
            end
            default: begin
                tick_nxt  = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_160KHz or negedge Reset_n) begin
        if (!Reset_n) begin
            shreg          <= '0;
            RX_data        <= '0;
            Data_Available <= 1'b0;
            Frame_Error    <= 1'b0;
            Overrun        <= 1'b0;
        end else begin
            Frame_Error <= frame_err;
            if (shift_en) shreg <= {line, shreg[DATA_BITS-1:1]};
            if (capture) begin
                // A read landing on the capture cycle consumes the old byte, so no overrun
                RX_data        <= shreg;
                Data_Available <= 1'b1;
                if (RX_Read)             Overrun <= 1'b0;
                else if (Data_Available) Overrun <= 1'b1;
            end else if (RX_Read && Data_Available) begin
                Data_Available <= 1'b0;
                Overrun        <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: vector table plus hand sequences, byte scoreboard.
module tb_uart_receiver;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       Reset_n;
    logic       TXD;
    logic       RX_Read;
    logic [7:0] RX_data;
    logic       Data_Available;
    logic       Frame_Error;
    logic       Overrun;

    int n_cmp   = 0;
    int n_err   = 0;
    int cyc     = 0;
    int t_start = 0;
    int fe_cnt  = 0;
    logic da_q  = 1'b0;
    logic fe_q  = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] last_good = 8'h00;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_fe;
    } vec_t;
    vec_t vecs[6];

    uart_receiver #(.OVERSAMPLE(OS)) dut (
        .clock_160KHz   (clk),
        .Reset_n        (Reset_n),
        .TXD            (TXD),
        .RX_Read        (RX_Read),
        .RX_data        (RX_data),
        .Data_Available (Data_Available),
        .Frame_Error    (Frame_Error),
        .Overrun        (Overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: each Data_Available rise pops one expected byte
    always @(negedge clk) begin
        if (Data_Available && !da_q) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_byte: got 0x%0h expected none", RX_data);
            end else begin
                check("rx_byte", 32'(RX_data), 32'(exp_q.pop_front()));
                check("latency_153_155",
                      32'((cyc - t_start >= 153) && (cyc - t_start <= 155)), 32'd1);
            end
        end
        if (Frame_Error) begin
            fe_cnt++;
            if (fe_q) begin
                n_cmp++;
                n_err++;
                $display("FAIL fe_width: got >1 cycle expected 1 cycle");
            end
        end
        da_q <= Data_Available;
        fe_q <= Frame_Error;
    end

    // All driving tasks start and end 1 time unit after a rising edge
    task automatic drive_bit(input logic b);
        TXD = b;
        repeat (OS) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        t_start = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic wait_da(input string name);
        int n = 0;
        while (!Data_Available && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 32'(Data_Available), 32'd1);
    endtask

    task automatic read_byte();
        RX_Read = 1'b1;
        @(posedge clk);
        #1;
        RX_Read = 1'b0;
        check("read_da_clear", 32'(Data_Available), 32'd0);
        check("read_ovr_clear", 32'(Overrun), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int fe0;
        logic [7:0] v;
        vecs[0] = '{8'h41, 1'b1, 1'b0};
        vecs[1] = '{8'h55, 1'b1, 1'b0};
        vecs[2] = '{8'h7E, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 1'b1, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 1'b0};
        vecs[5] = '{8'hA5, 1'b1, 1'b0};

        Reset_n = 1'b0;
        TXD     = 1'b1;
        RX_Read = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_data", 32'(RX_data), 32'd0);
        check("rst_da", 32'(Data_Available), 32'd0);
        check("rst_fe", 32'(Frame_Error), 32'd0);
        check("rst_ovr", 32'(Overrun), 32'd0);
        Reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Short low glitch must not start a frame
        fe0 = fe_cnt;
        TXD = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        TXD = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("glitch_no_da", 32'(Data_Available), 32'd0);
        check("glitch_no_fe", 32'(fe_cnt - fe0), 32'd0);

        for (int i = 0; i < 6; i++) begin
            fe0 = fe_cnt;
            if (vecs[i].stop) exp_q.push_back(vecs[i].data);
            send_frame(vecs[i].data, vecs[i].stop);
            if (vecs[i].exp_fe) begin
                // Line stays low (break); no further events until it goes high
                repeat (40) @(posedge clk);
                #1;
                check("break_fe_once", 32'(fe_cnt - fe0), 32'd1);
                TXD = 1'b1;
                repeat (20) @(posedge clk);
                #1;
                check("fe_total_once", 32'(fe_cnt - fe0), 32'd1);
                check("fe_rx_data_hold", 32'(RX_data), 32'(last_good));
                check("fe_da_unchanged", 32'(Data_Available), 32'd0);
            end else begin
                wait_da("vec_da");
                check("vec_no_fe", 32'(fe_cnt - fe0), 32'd0);
                read_byte();
                last_good = vecs[i].data;
            end
        end

        // Back-to-back frames with a reader running alongside
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    exp_q.push_back(8'h20 + 8'(k));
                    send_frame(8'h20 + 8'(k), 1'b1);
                end
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    wait_da("b2b_da");
                    read_byte();
                end
            end
        join
        repeat (10) @(posedge clk);
        #1;

        // Overrun: second byte lands while the first is unread
        exp_q.push_back(8'h30);
        send_frame(8'h30, 1'b1);
        send_frame(8'h31, 1'b1);
        check("ovr_rx_data", 32'(RX_data), 32'h31);
        check("ovr_flag", 32'(Overrun), 32'd1);
        check("ovr_da", 32'(Data_Available), 32'd1);
        read_byte();

        // Reset during data bit 4 with an unread byte pending
        exp_q.push_back(8'h66);
        send_frame(8'h66, 1'b1);
        v = 8'h5A;
        t_start = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(v[i]);
        TXD = v[4];
        repeat (8) @(posedge clk);
        #1;
        Reset_n = 1'b0;
        #2;
        check("midrst_rx_data", 32'(RX_data), 32'd0);
        check("midrst_da", 32'(Data_Available), 32'd0);
        check("midrst_fe", 32'(Frame_Error), 32'd0);
        check("midrst_ovr", 32'(Overrun), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        TXD     = 1'b1;
        Reset_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("postrst_no_da", 32'(Data_Available), 32'd0);
        exp_q.push_back(8'h33);
        send_frame(8'h33, 1'b1);
        wait_da("postrst_da");
        check("postrst_byte", 32'(RX_data), 32'h33);
        read_byte();

        repeat (5) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
